// File: rtl/core_pkg.sv
// Shared definitions for the RV core pipeline: load funct3 codes, default
// datapath width and the writeback result selector.
// Pure declarations; no logic, no latency, no flow control.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Load size/sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    WB_ALU,
    WB_LOAD,
    WB_LUI,
    WB_AUIPC,
    WB_LINK
  } wb_sel_e;

endpackage

// File: rtl/load_extend.sv
// Extracts a byte/half/word/double from an aligned memory word and extends it.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] byte_off,
  input  logic [XLEN-1:0]  raw,
  output logic [XLEN-1:0]  data
);

  logic [OFF_W-1:0] eff_off;
  logic [XLEN-1:0]  shifted;

  // Align the offset to the access size, shift the wanted lane down, then extend
  always_comb begin
    eff_off = byte_off;
    case (funct3)
      F3_LB, F3_LBU: ;
      F3_LH, F3_LHU: eff_off[0] = 1'b0;
      F3_LD: begin
        if (XLEN == 64) eff_off = '0;
        else            eff_off[1:0] = 2'b00;
      end
      default: eff_off[1:0] = 2'b00;
    endcase

    shifted = raw >> {eff_off, 3'b000};

    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH:  data = XLEN'($signed(shifted[15:0]));
      F3_LHU: data = XLEN'(shifted[15:0]);
      F3_LWU: begin
        // Unsigned word only exists on RV64; on RV32 it degrades to LW
        if (XLEN == 64) data = XLEN'(shifted[31:0]);
        else            data = XLEN'($signed(shifted[31:0]));
      end
      F3_LD: begin
        if (XLEN == 64) data = shifted;
        else            data = XLEN'($signed(shifted[31:0]));
      end
      default: data = XLEN'($signed(shifted[31:0]));
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register, result select, load extension, retire count.
// One cycle from MEM inputs to outputs; outputs depend on WB registers only.
// Stall holds the register, flush kills the captured instruction.
module wb_stage_pipe
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_is_lui,
  input  logic              i_is_auipc,
  input  logic              i_jump,
  input  logic [2:0]        i_funct3,
  input  logic [OFF_W-1:0]  i_byte_off,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_pc_plus4,
  input  logic [XLEN-1:0]   i_imm,
  output logic              o_valid,
  output logic              o_rd_we,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd_data,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              is_lui;
    logic              is_auipc;
    logic              jump;
    logic [2:0]        funct3;
    logic [OFF_W-1:0]  byte_off;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
  } wb_reg_t;

  wb_reg_t          wb_q;
  logic [CNT_W-1:0] retire_q;
  wb_sel_e          wb_sel;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  rd_data;

  // Pipeline register and retire counter; the resident instruction retires when it leaves
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_q     <= '0;
      retire_q <= '0;
    end else begin
      if (wb_q.valid && (!i_stall || i_flush)) retire_q <= retire_q + CNT_W'(1);
      if (i_flush) begin
        wb_q.valid <= 1'b0;
      end else if (!i_stall) begin
        wb_q <= '{valid:      i_valid,
                  reg_write:  i_reg_write,
                  mem_read:   i_mem_read,
                  is_lui:     i_is_lui,
                  is_auipc:   i_is_auipc,
                  jump:       i_jump,
                  funct3:     i_funct3,
                  byte_off:   i_byte_off,
                  rd_addr:    i_rd_addr,
                  mem_data:   i_mem_data,
                  alu_result: i_alu_result,
                  pc:         i_pc,
                  pc_plus4:   i_pc_plus4,
                  imm:        i_imm};
      end
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3   (wb_q.funct3),
    .byte_off (wb_q.byte_off),
    .raw      (wb_q.mem_data),
    .data     (load_data)
  );

  // Result source priority: link, LUI, AUIPC, load, ALU
  always_comb begin
    wb_sel = WB_ALU;
    if      (wb_q.jump)     wb_sel = WB_LINK;
    else if (wb_q.is_lui)   wb_sel = WB_LUI;
    else if (wb_q.is_auipc) wb_sel = WB_AUIPC;
    else if (wb_q.mem_read) wb_sel = WB_LOAD;
  end

  // Writeback data mux; AUIPC sum wraps at XLEN bits
  always_comb begin
    case (wb_sel)
      WB_LINK:  rd_data = wb_q.pc_plus4;
      WB_LUI:   rd_data = wb_q.imm;
      WB_AUIPC: rd_data = wb_q.pc + wb_q.imm;
      WB_LOAD:  rd_data = load_data;
      default:  rd_data = wb_q.alu_result;
    endcase
  end

  assign o_valid      = wb_q.valid;
  assign o_rd_we      = wb_q.valid & wb_q.reg_write & (wb_q.rd_addr != '0);
  assign o_rd_addr    = wb_q.rd_addr;
  assign o_rd_data    = rd_data;
  assign o_retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: an RV32 instance (4-bit retire counter) and an RV64
// instance share one stimulus stream; a transaction-level reference model
// predicts every output, plus directed vector table and corner sequences.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, stall, flush, reg_write, mem_read, lui, auipc, jump;
  logic [2:0]  f3, off;
  logic [4:0]  rd;
  logic [63:0] mem, alu, pc, pc4, imm;

  logic        v32, we32, v64, we64;
  logic [4:0]  ra32, ra64;
  logic [31:0] rdat32, cnt64;
  logic [63:0] rdat64;
  logic [3:0]  cnt32;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_is_lui(lui), .i_is_auipc(auipc),
    .i_jump(jump), .i_funct3(f3), .i_byte_off(off[1:0]), .i_rd_addr(rd),
    .i_mem_data(mem[31:0]), .i_alu_result(alu[31:0]), .i_pc(pc[31:0]),
    .i_pc_plus4(pc4[31:0]), .i_imm(imm[31:0]),
    .o_valid(v32), .o_rd_we(we32), .o_rd_addr(ra32), .o_rd_data(rdat32), .o_retire_cnt(cnt32)
  );

  wb_stage_pipe #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_is_lui(lui), .i_is_auipc(auipc),
    .i_jump(jump), .i_funct3(f3), .i_byte_off(off), .i_rd_addr(rd),
    .i_mem_data(mem), .i_alu_result(alu), .i_pc(pc), .i_pc_plus4(pc4), .i_imm(imm),
    .o_valid(v64), .o_rd_we(we64), .o_rd_addr(ra64), .o_rd_data(rdat64), .o_retire_cnt(cnt64)
  );

  typedef struct packed {
    logic        valid, rw, mr, lui, auipc, jump;
    logic [2:0]  f3, off;
    logic [4:0]  rd;
    logic [63:0] mem, alu, pc, pc4, imm;
  } txn_t;

  typedef struct {
    txn_t        t;
    bit          is64;
    logic [63:0] exp;
  } vec_t;

  // Reference model state: the instruction sitting in WB and retirements so far
  txn_t            m;
  bit              m_known;
  longint unsigned m_cnt;

  function automatic logic [63:0] ref_load(logic [63:0] raw, logic [2:0] fn, logic [2:0] bo, int xlen);
    int n = 4;
    bit sgn = 1;
    int o;
    logic [63:0] full, fmask, v;
    full = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (fn)
      3'd0: n = 1;
      3'd4: begin n = 1; sgn = 0; end
      3'd1: n = 2;
      3'd5: begin n = 2; sgn = 0; end
      3'd6: if (xlen == 64) sgn = 0;
      3'd3: if (xlen == 64) n = 8;
      default: ;
    endcase
    o = int'(bo) % (xlen / 8);
    o = o - (o % n);
    v = (raw & full) >> (o * 8);
    fmask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (n * 8)) - 64'd1);
    v = v & fmask;
    if (sgn && v[n*8-1]) v = v | ~fmask;
    return v & full;
  endfunction

  function automatic logic [63:0] ref_data(txn_t t, int xlen);
    logic [63:0] full, r;
    full = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if      (t.jump)  r = t.pc4;
    else if (t.lui)   r = t.imm;
    else if (t.auipc) r = t.pc + t.imm;
    else if (t.mr)    r = ref_load(t.mem, t.f3, t.off, xlen);
    else              r = t.alu;
    return r & full;
  endfunction

  function automatic txn_t cur_in();
    txn_t t;
    t.valid = valid; t.rw = reg_write; t.mr = mem_read; t.lui = lui; t.auipc = auipc;
    t.jump = jump; t.f3 = f3; t.off = off; t.rd = rd; t.mem = mem; t.alu = alu;
    t.pc = pc; t.pc4 = pc4; t.imm = imm;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m = '0; m_known = 1'b1; m_cnt = 0;
    end else begin
      if (m.valid && (!stall || flush)) m_cnt++;
      if (flush) begin
        m.valid = 1'b0; m_known = 1'b0;
      end else if (!stall) begin
        m = cur_in(); m_known = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic we;
    we = m.valid & m.rw & (m.rd != 5'd0);
    chk("valid32", {63'd0, v32}, {63'd0, m.valid});
    chk("valid64", {63'd0, v64}, {63'd0, m.valid});
    chk("we32", {63'd0, we32}, {63'd0, we});
    chk("we64", {63'd0, we64}, {63'd0, we});
    chk("cnt32", {60'd0, cnt32}, m_cnt % 16);
    chk("cnt64", {32'd0, cnt64}, m_cnt & 64'hFFFF_FFFF);
    if (m_known) begin
      chk("addr32", {59'd0, ra32}, {59'd0, m.rd});
      chk("addr64", {59'd0, ra64}, {59'd0, m.rd});
      chk("data32", {32'd0, rdat32}, ref_data(m, 32));
      chk("data64", rdat64, ref_data(m, 64));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic drive(txn_t t);
    valid = t.valid; reg_write = t.rw; mem_read = t.mr; lui = t.lui; auipc = t.auipc;
    jump = t.jump; f3 = t.f3; off = t.off; rd = t.rd; mem = t.mem; alu = t.alu;
    pc = t.pc; pc4 = t.pc4; imm = t.imm;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.valid = 1'($urandom); t.rw = 1'($urandom); t.mr = 1'($urandom);
    t.lui = ($urandom_range(0, 5) == 0); t.auipc = ($urandom_range(0, 5) == 0);
    t.jump = ($urandom_range(0, 5) == 0);
    t.f3 = 3'($urandom); t.off = 3'($urandom); t.rd = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    t.mem = {$urandom, $urandom}; t.alu = {$urandom, $urandom}; t.pc = {$urandom, $urandom};
    t.pc4 = {$urandom, $urandom}; t.imm = {$urandom, $urandom};
    return t;
  endfunction

  function automatic txn_t base(logic [4:0] r);
    txn_t t = '0;
    t.valid = 1'b1; t.rw = 1'b1; t.rd = r; t.alu = 64'hDEAD_BEEF;
    return t;
  endfunction

  function automatic txn_t ld(logic [2:0] fn, logic [2:0] bo, logic [63:0] raw);
    txn_t t = base(5'd3);
    t.mr = 1'b1; t.f3 = fn; t.off = bo; t.mem = raw;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    txn_t t;
    longint unsigned c0;

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive('0);

    // Directed vectors: 32-bit load lanes, select priority, 64-bit loads
    t = base(5'd5); t.alu = 64'h1234;
    tbl.push_back('{t, 1'b0, 64'h0000_1234});
    tbl.push_back('{ld(3'b000, 3'd3, 64'h80FF7F01), 1'b0, 64'hFFFF_FF80});
    tbl.push_back('{ld(3'b100, 3'd1, 64'h80FF7F01), 1'b0, 64'h0000_007F});
    tbl.push_back('{ld(3'b001, 3'd2, 64'h80FF7F01), 1'b0, 64'hFFFF_80FF});
    tbl.push_back('{ld(3'b101, 3'd3, 64'h80FF7F01), 1'b0, 64'h0000_80FF});
    tbl.push_back('{ld(3'b011, 3'd2, 64'h80FF7F01), 1'b0, 64'h80FF_7F01});
    tbl.push_back('{ld(3'b111, 3'd1, 64'h80FF7F01), 1'b0, 64'h80FF_7F01});
    t = base(5'd1); t.jump = 1'b1; t.lui = 1'b1; t.pc4 = 64'h104; t.imm = 64'hABC0_0000;
    tbl.push_back('{t, 1'b0, 64'h0000_0104});
    t = base(5'd2); t.auipc = 1'b1; t.mr = 1'b1; t.pc = 64'hFFFF_F000; t.imm = 64'h2000;
    tbl.push_back('{t, 1'b0, 64'h0000_1000});
    tbl.push_back('{ld(3'b010, 3'd0, 64'h80000000_FFFFFFFE), 1'b1, 64'hFFFFFFFF_FFFFFFFE});
    tbl.push_back('{ld(3'b110, 3'd4, 64'h80000000_FFFFFFFE), 1'b1, 64'h00000000_80000000});
    tbl.push_back('{ld(3'b011, 3'd5, 64'h80000000_FFFFFFFE), 1'b1, 64'h80000000_FFFFFFFE});
    tbl.push_back('{ld(3'b000, 3'd7, 64'h80000000_FFFFFFFE), 1'b1, 64'hFFFFFFFF_FFFFFF80});

    // Reset state
    rst = 1'b1; step();
    chk("rst_valid", {63'd0, v32 | v64}, 64'd0);
    chk("rst_we", {63'd0, we32 | we64}, 64'd0);
    chk("rst_addr", {59'd0, ra32 | ra64}, 64'd0);
    chk("rst_data", {32'd0, rdat32} | rdat64, 64'd0);
    chk("rst_cnt", {32'd0, cnt64} | {60'd0, cnt32}, 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].t);
      step();
      if (tbl[i].is64) chk($sformatf("vec%0d", i), rdat64, tbl[i].exp);
      else             chk($sformatf("vec%0d", i), {32'd0, rdat32}, tbl[i].exp);
    end

    // Stall for three cycles with changing inputs: outputs hold, one retirement total
    t = base(5'd7); t.alu = 64'hA5;
    drive(t); step();
    c0 = m_cnt;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(rnd_txn()); step();
      chk("stall_hold", {32'd0, rdat32}, 64'hA5);
      chk("stall_cnt", {60'd0, cnt32}, c0 % 16);
    end
    stall = 1'b0; valid = 1'b0; step();
    chk("stall_retire", {60'd0, cnt32}, (c0 + 1) % 16);
    chk("stall_after_valid", {63'd0, v32}, 64'd0);

    // Flush together with stall kills the incoming instruction
    drive(base(5'd9)); step();
    stall = 1'b1; flush = 1'b1; drive(base(5'd10)); step();
    chk("flush_valid", {63'd0, v32 | v64}, 64'd0);
    chk("flush_we", {63'd0, we32 | we64}, 64'd0);
    stall = 1'b0; flush = 1'b0;

    // rd=0 never writes but still retires
    drive(base(5'd0)); step();
    chk("rd0_we", {63'd0, we32}, 64'd0);
    c0 = m_cnt;
    valid = 1'b0; step();
    chk("rd0_retire", {32'd0, cnt64}, (c0 + 1) & 64'hFFFF_FFFF);

    // Sixteen retirements wrap the 4-bit counter to zero
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(base(5'($urandom_range(1, 31)))); step();
    end
    valid = 1'b0; step();
    chk("wrap_cnt32", {60'd0, cnt32}, 64'd0);
    chk("wrap_cnt64", {32'd0, cnt64}, 64'd16);

    // Mid-stream reset wins over stall and flush
    drive(base(5'd4)); step();
    drive(base(5'd6)); rst = 1'b1; stall = 1'b1; flush = 1'b1; step();
    chk("mrst_valid", {63'd0, v32 | v64}, 64'd0);
    chk("mrst_data", {32'd0, rdat32} | rdat64, 64'd0);
    chk("mrst_cnt", {32'd0, cnt64} | {60'd0, cnt32}, 64'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive(rnd_txn());
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
